// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: fetch has priority, a bounded fetch streak
// guarantees load/store progress, and read responses are routed back to their issuer.
module imem_port_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_FETCH_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      fetch_req,
   input  logic [ADDR_WIDTH-1:0]     fetch_addr,
   output logic                      fetch_gnt,
   output logic                      fetch_stall,
   output logic                      fetch_rvalid,
   output logic [DATA_WIDTH-1:0]     fetch_rdata,
   input  logic                      ls_req,
   input  logic                      ls_we,
   input  logic [ADDR_WIDTH-1:0]     ls_addr,
   input  logic [DATA_WIDTH-1:0]     ls_wdata,
   input  logic [DATA_WIDTH/8-1:0]   ls_be,
   output logic                      ls_gnt,
   output logic                      ls_rvalid,
   output logic [DATA_WIDTH-1:0]     ls_rdata,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_be,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   // state     | meaning
   // OWN_NONE  | no read issued last cycle (idle or ls write)
   // OWN_FETCH | last cycle issued a fetch read; data returns now
   // OWN_LS    | last cycle issued an ls read; data returns now

   localparam logic [3:0] MAX_STREAK = 4'(MAX_FETCH_BURST);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LS    = 2'd2
   } owner_t;

   owner_t     r_owner;
   owner_t     w_owner_nxt;
   logic [3:0] r_streak;
   logic [3:0] w_streak_nxt;
   logic       w_fetch_ok;
   logic       w_fetch_win;
   logic       w_fetch_gnt;
   logic       w_ls_gnt;

   // Fetch wins unless ls is waiting and the fetch streak has hit its cap.
   assign w_fetch_ok  = fetch_req & ~flush;
   assign w_fetch_win = w_fetch_ok & (~ls_req | (r_streak < MAX_STREAK));
   assign w_fetch_gnt = w_fetch_win & ~rst;
   assign w_ls_gnt    = ls_req & ~w_fetch_win & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner  <= OWN_NONE;
         r_streak <= 4'd0;
      end else begin
         r_owner  <= w_owner_nxt;
         r_streak <= w_streak_nxt;
      end
   end

   always_comb begin
      w_owner_nxt  = OWN_NONE;
      w_streak_nxt = r_streak;
      if (w_fetch_gnt)
         w_owner_nxt = OWN_FETCH;
      else if (w_ls_gnt && !ls_we)
         w_owner_nxt = OWN_LS;

      if (!ls_req || w_ls_gnt)
         w_streak_nxt = 4'd0;
      else if (w_fetch_gnt && (r_streak < MAX_STREAK))
         w_streak_nxt = r_streak + 4'd1;
   end

   always_comb begin
      fetch_gnt    = w_fetch_gnt;
      ls_gnt       = w_ls_gnt;
      fetch_stall  = fetch_req & ~w_fetch_gnt & ~rst;
      mem_req      = w_fetch_gnt | w_ls_gnt;
      mem_we       = w_ls_gnt & ls_we;
      mem_addr     = w_fetch_gnt ? fetch_addr : ls_addr;
      mem_wdata    = ls_wdata;
      mem_be       = w_fetch_gnt ? {(DATA_WIDTH/8){1'b1}} : ls_be;
      // A flush in the return cycle kills the now-stale fetch data.
      fetch_rvalid = (r_owner == OWN_FETCH) & ~flush & ~rst;
      ls_rvalid    = (r_owner == OWN_LS) & ~rst;
      fetch_rdata  = mem_rdata;
      ls_rdata     = mem_rdata;
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed cycle table followed by random traffic
// compared against a cycle-level reference model.
module tb_imem_port_arbiter;
   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst, flush, fetch_req, ls_req, ls_we;
   logic [31:0] fetch_addr, ls_addr, ls_wdata, mem_rdata;
   logic [3:0]  ls_be;
   logic        fetch_gnt, fetch_stall, fetch_rvalid, ls_gnt, ls_rvalid;
   logic        mem_req, mem_we;
   logic [31:0] fetch_rdata, ls_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int n_err = 0;
   int n_chk = 0;

   imem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_FETCH_BURST(MAXB)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_stall(fetch_stall), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, flush, freq;
      logic [31:0] faddr;
      logic        lreq, lwe;
      logic [31:0] laddr, lwdata;
      logic [3:0]  lbe;
      logic [31:0] rdata;
      logic [4:0]  exp;   // {fetch_gnt, ls_gnt, fetch_stall, fetch_rvalid, ls_rvalid}
   } vec_t;

   vec_t vecs[$];

   task automatic row(input logic r, fl, fq, input logic [31:0] fa, input logic lq, lw,
                      input logic [31:0] la, wd, input logic [3:0] be,
                      input logic [31:0] rd, input logic [4:0] ex);
      vec_t v;
      v.rst = r; v.flush = fl; v.freq = fq; v.faddr = fa; v.lreq = lq; v.lwe = lw;
      v.laddr = la; v.lwdata = wd; v.lbe = be; v.rdata = rd; v.exp = ex;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic r, fl, fq, input logic [31:0] fa, input logic lq, lw,
                        input logic [31:0] la, wd, input logic [3:0] be, input logic [31:0] rd);
      rst = r; flush = fl; fetch_req = fq; fetch_addr = fa; ls_req = lq; ls_we = lw;
      ls_addr = la; ls_wdata = wd; ls_be = be; mem_rdata = rd;
   endtask

   task automatic compare_all(input string tag, input logic fg, lg, fs, frv, lrv);
      chk({tag, " fetch_gnt"},    32'(fetch_gnt),    32'(fg));
      chk({tag, " ls_gnt"},       32'(ls_gnt),       32'(lg));
      chk({tag, " fetch_stall"},  32'(fetch_stall),  32'(fs));
      chk({tag, " fetch_rvalid"}, 32'(fetch_rvalid), 32'(frv));
      chk({tag, " ls_rvalid"},    32'(ls_rvalid),    32'(lrv));
      chk({tag, " mem_req"},      32'(mem_req),      32'(fg | lg));
      chk({tag, " mem_we"},       32'(mem_we),       32'(lg & ls_we));
      chk({tag, " mem_addr"},     mem_addr,          fg ? fetch_addr : ls_addr);
      if (lg) begin
         chk({tag, " mem_wdata"}, mem_wdata,         ls_wdata);
         chk({tag, " mem_be"},    32'(mem_be),       32'(ls_be));
      end
      if (fg) chk({tag, " mem_be_fetch"}, 32'(mem_be), 32'hF);
      if (frv) chk({tag, " fetch_rdata"}, fetch_rdata, mem_rdata);
      if (lrv) chk({tag, " ls_rdata"},    ls_rdata,    mem_rdata);
   endtask

   initial begin
      int m_streak, m_owner;   // owner: 0 none, 1 fetch, 2 ls
      logic fok, fg, lg, fs, frv, lrv;
      logic r, fl, fq, lq, lw;
      logic [31:0] fa, la, wd, rd;
      logic [3:0] be;

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // reset then idle
      repeat (2) row(1,0,0,0, 0,0,0,0,0, 0, 5'b00000);
      repeat (5) row(0,0,0,0, 0,0,0,0,0, 0, 5'b00000);
      // fetch only
      row(0,0,1,32'h0, 0,0,0,0,0, 32'h0,   5'b10000);
      row(0,0,1,32'h4, 0,0,0,0,0, 32'h13,  5'b10010);
      row(0,0,1,32'h8, 0,0,0,0,0, 32'h93,  5'b10010);
      row(0,0,0,32'h0, 0,0,0,0,0, 32'h113, 5'b00010);
      // contention, burst cap 4
      row(0,0,1,32'h200, 1,0,32'h100,0,4'hF, 32'hA0, 5'b10000);
      row(0,0,1,32'h204, 1,0,32'h100,0,4'hF, 32'hA1, 5'b10010);
      row(0,0,1,32'h208, 1,0,32'h100,0,4'hF, 32'hA2, 5'b10010);
      row(0,0,1,32'h20C, 1,0,32'h100,0,4'hF, 32'hA3, 5'b10010);
      row(0,0,1,32'h210, 1,0,32'h100,0,4'hF, 32'hA4, 5'b01110);
      row(0,0,1,32'h210, 0,0,32'h100,0,4'hF, 32'hB0, 5'b10001);
      row(0,0,0,32'h0,   0,0,0,0,0,          32'hB1, 5'b00010);
      // write
      row(0,0,0,0, 1,1,32'h40,32'hDEADBEEF,4'b0011, 32'h0, 5'b01000);
      row(0,0,0,0, 0,0,0,0,0,                     32'h55, 5'b00000);
      // flush
      row(0,0,1,32'h20, 0,0,0,0,0, 32'h0,  5'b10000);
      row(0,1,1,32'h24, 0,0,0,0,0, 32'h66, 5'b00100);
      row(0,0,1,32'h24, 0,0,0,0,0, 32'h67, 5'b10000);
      row(0,0,0,32'h0,  0,0,0,0,0, 32'h77, 5'b00010);
      // reset with ls read in flight
      row(0,0,0,0, 1,0,32'h80,0,4'hF, 32'h0,  5'b01000);
      row(1,0,0,0, 0,0,0,0,0,         32'h88, 5'b00000);
      row(0,0,0,0, 0,0,0,0,0,         32'h89, 5'b00000);
      // reset clears a partial streak: full burst of 4 required afterwards
      row(0,0,1,32'h300, 1,0,32'h180,0,4'hF, 32'h1, 5'b10000);
      row(0,0,1,32'h304, 1,0,32'h180,0,4'hF, 32'h2, 5'b10010);
      row(0,0,1,32'h308, 1,0,32'h180,0,4'hF, 32'h3, 5'b10010);
      row(1,0,1,32'h30C, 1,0,32'h180,0,4'hF, 32'h4, 5'b00000);
      row(0,0,1,32'h30C, 1,0,32'h180,0,4'hF, 32'h5, 5'b10000);
      row(0,0,1,32'h310, 1,0,32'h180,0,4'hF, 32'h6, 5'b10010);
      row(0,0,1,32'h314, 1,0,32'h180,0,4'hF, 32'h7, 5'b10010);
      row(0,0,1,32'h318, 1,0,32'h180,0,4'hF, 32'h8, 5'b10010);
      row(0,0,1,32'h31C, 1,0,32'h180,0,4'hF, 32'h9, 5'b01110);
      row(0,0,0,0,       0,0,0,0,0,          32'hA, 5'b00001);
      // ls_req dropping mid-streak clears it
      row(0,0,1,32'h400, 1,0,32'h1C0,0,4'hF, 32'h11, 5'b10000);
      row(0,0,1,32'h404, 1,0,32'h1C0,0,4'hF, 32'h12, 5'b10010);
      row(0,0,1,32'h408, 0,0,32'h1C0,0,4'hF, 32'h13, 5'b10010);
      row(0,0,1,32'h40C, 1,0,32'h1C0,0,4'hF, 32'h14, 5'b10010);
      row(0,0,1,32'h410, 1,0,32'h1C0,0,4'hF, 32'h15, 5'b10010);
      row(0,0,1,32'h414, 1,0,32'h1C0,0,4'hF, 32'h16, 5'b10010);
      row(0,0,1,32'h418, 1,0,32'h1C0,0,4'hF, 32'h17, 5'b10010);
      row(0,0,1,32'h41C, 1,0,32'h1C0,0,4'hF, 32'h18, 5'b01110);
      row(0,0,0,0,       0,0,0,0,0,          32'h19, 5'b00001);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].flush, vecs[i].freq, vecs[i].faddr, vecs[i].lreq,
               vecs[i].lwe, vecs[i].laddr, vecs[i].lwdata, vecs[i].lbe, vecs[i].rdata);
         #1;
         compare_all($sformatf("vec%0d", i), vecs[i].exp[4], vecs[i].exp[3],
                     vecs[i].exp[2], vecs[i].exp[1], vecs[i].exp[0]);
      end

      // random traffic against the reference model
      m_streak = 0;
      m_owner  = 0;
      for (int i = 0; i < 800; i++) begin
         r  = (i == 0) || ($urandom_range(0, 39) == 0);
         fl = ($urandom_range(0, 5) == 0);
         fq = ($urandom_range(0, 9) < 7);
         lq = ($urandom_range(0, 9) < 6);
         lw = ($urandom_range(0, 3) == 0);
         fa = $urandom & 32'hFFFF_FFFC;
         la = $urandom;
         wd = $urandom;
         be = 4'($urandom);
         rd = $urandom;
         @(negedge clk);
         drive(r, fl, fq, fa, lq, lw, la, wd, be, rd);

         fok = fq && !fl;
         if (r) begin
            fg = 0; lg = 0;
         end else if (fok && lq) begin
            fg = (m_streak < MAXB);
            lg = !fg;
         end else begin
            fg = fok; lg = lq;
         end
         fs  = fq && !fg && !r;
         frv = (m_owner == 1) && !fl && !r;
         lrv = (m_owner == 2) && !r;
         #1;
         compare_all($sformatf("rnd%0d", i), fg, lg, fs, frv, lrv);

         if (r) begin
            m_streak = 0;
            m_owner  = 0;
         end else begin
            m_owner = fg ? 1 : ((lg && !lw) ? 2 : 0);
            if (!lq || lg)  m_streak = 0;
            else if (fg)    m_streak = (m_streak + 1 > MAXB) ? MAXB : m_streak + 1;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbitrates the single-port instruction memory between the instruction fetch stage and a secondary load/store requester (data-side loads of constants from code space and the program loader). Fetch has priority, and a bounded-starvation counter guarantees the load/store side a grant. The block routes the one-cycle-latency read response back to the requester that issued it, and drops in-flight fetch responses on a pipeline flush (misprediction). It sits between `if_stage`/`bpu` and the instruction memory macro.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width of both requesters and the memory port.
- `DATA_WIDTH`, 32: word width. Must be a multiple of 8.
- `MAX_FETCH_BURST`, 4: maximum consecutive fetch grants while a load/store request waits. Range 1..15.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush (misprediction/redirect); kills fetch traffic.
- `fetch_req`  in  1  fetch read request.
- `fetch_addr`  in  ADDR_WIDTH  fetch byte address (word-aligned).
- `fetch_gnt`  out  1  fetch request accepted this cycle.
- `fetch_stall`  out  1  `fetch_req & ~fetch_gnt`; drives IF stall.
- `fetch_rvalid`  out  1  fetch read data valid.
- `fetch_rdata`  out  DATA_WIDTH  fetch read data.
- `ls_req`  in  1  load/store request.
- `ls_we`  in  1  1 = write, 0 = read.
- `ls_addr`  in  ADDR_WIDTH  load/store byte address.
- `ls_wdata`  in  DATA_WIDTH  write data.
- `ls_be`  in  DATA_WIDTH/8  write byte enables.
- `ls_gnt`  out  1  load/store request accepted this cycle.
- `ls_rvalid`  out  1  load read data valid. Never asserted for writes.
- `ls_rdata`  out  DATA_WIDTH  load read data.
- `mem_req`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_be`  out  DATA_WIDTH/8  memory byte enables.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid one cycle after a read.

## Operation
Grant decision is combinational and made each cycle.

- `fetch_ok = fetch_req & ~flush`.
- If only one of `fetch_ok` and `ls_req` is high, that requester is granted.
- If both are high, fetch is granted while `streak < MAX_FETCH_BURST`. Otherwise ls is granted.
- At most one grant per cycle.

Mux and memory port:
- `mem_req = fetch_gnt | ls_gnt`.
- On a fetch grant: `mem_we = 0`, `mem_addr = fetch_addr`, `mem_be` = all ones.
- On an ls grant: all `mem_*` fields come from the `ls_*` inputs.
- When idle, `mem_addr`/`mem_wdata`/`mem_be` hold the ls values, with `mem_we = 0`.

`streak` register (4 bits):
- Increments when fetch is granted while `ls_req` is high.
- Clears to 0 when ls is granted or `ls_req` is low.
- Saturates at `MAX_FETCH_BURST`.

Response owner register `owner_q`, one of NONE/FETCH/LS:
- Set to FETCH on a fetch grant.
- Set to LS on an ls read grant.
- Otherwise set to NONE, including ls writes.

Response routing:
- `fetch_rvalid = (owner_q == FETCH) & ~flush`.
- `ls_rvalid = (owner_q == LS)`.
- Both rdata outputs pass `mem_rdata` through unregistered.

Flush:
- Blocks any fetch grant in the flush cycle.
- Suppresses a fetch response returning in the flush cycle.
- Has no effect on ls traffic or on `streak`.

## Timing
Reset values (sampled `rst=1`):
- `owner_q` = NONE, `streak` = 0.
- During reset, all grants, `mem_req`, `fetch_rvalid`, `ls_rvalid` and `fetch_stall` are forced to 0.

Latency:
- Grant occurs in the request cycle N.
- The response (rvalid + rdata) appears in cycle N+1.
- Back-to-back requests every cycle are sustained at full throughput.

Handshake:
- A requester holds `req`/address stable until it sees `gnt`.
- No response buffering: requesters must accept rvalid in the cycle it appears.

Boundary cases:
- Reset asserted while a read is in flight: the response is discarded and no rvalid is ever produced.
- Flush in cycle N+1 of a fetch read: `fetch_rvalid` stays 0 in N+1.
- Simultaneous requests with `streak == MAX_FETCH_BURST-1`: fetch wins and `streak` reaches MAX. On the next contended cycle ls wins.
- `ls_req` deasserting mid-streak clears `streak`.
- ls write: `ls_gnt` high, `mem_we` high, no `ls_rvalid` in the following cycle.

## Test plan
- Reset then idle: `rst=1` for 2 cycles, then all reqs 0 → every output 0 and `mem_req=0` for 5 cycles.
- Fetch only:
  - Stimulus: `fetch_req=1`, addresses 0x0, 0x4, 0x8 on consecutive cycles; `mem_rdata` returns 0x13, 0x93, 0x113.
  - Required: `fetch_gnt=1` each cycle; `fetch_rvalid` high one cycle later with matching data; `fetch_stall=0`.
- Contention, `MAX_FETCH_BURST=4`:
  - Stimulus: `fetch_req` and `ls_req` (read, 0x100) both held high.
  - Required: fetch granted cycles 0-3, ls granted cycle 4 (`fetch_stall=1` in cycle 4), `ls_rvalid` cycle 5, fetch granted again cycle 5.
- Write:
  - Stimulus: `ls_we=1`, `ls_addr=0x40`, `ls_wdata=0xDEADBEEF`, `ls_be=4'b0011`, no fetch.
  - Required: `mem_we=1` with the same fields in that cycle; `ls_rvalid=0` in the next cycle.
- Flush:
  - Stimulus: fetch read 0x20 granted cycle 0; `flush=1` in cycle 1 with `fetch_req=1`.
  - Required: `fetch_rvalid=0` in cycle 1, `fetch_gnt=0` in cycle 1, `fetch_stall=1` in cycle 1; normal grant resumes cycle 2.
- Reset mid-flight:
  - Stimulus: ls read granted cycle 0; `rst=1` in cycle 1.
  - Required: `ls_rvalid=0` in cycles 1 and 2, and `streak` reads 0 after reset.
